// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-order definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_NOTA = 4'd0;
    localparam logic [3:0] OP_NOTB = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Bit positions inside the packed flag vector {c, n, z, v}.
    localparam int FLAG_W = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational result/flag/err for every opcode except multiply.
// Latency 0; no handshake, the caller registers the outputs.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [3:0]        op_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [FLAG_W-1:0] flags_o,
    output logic              err_o
);

    typedef logic [WIDTH-1:0] word_t;
    localparam word_t W_LIM = word_t'(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;
    logic [CNT_W-2:0] shamt;
    logic             is_sub;
    logic             shift_oob;

    always_comb begin
        is_sub    = (op_i == OP_SUB);
        b_eff     = is_sub ? ~b_i : b_i;
        sum       = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        shamt     = b_i[CNT_W-2:0];
        // The whole of b is range-checked, so large amounts flush to zero.
        shift_oob = (b_i >= W_LIM);

        result_o = '0;
        flags_o  = '0;
        err_o    = 1'b0;
        case (op_i)
            OP_NOTA: result_o = ~a_i;
            OP_NOTB: result_o = ~b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_ADD, OP_SUB: begin
                result_o        = sum[WIDTH-1:0];
                flags_o[FLAG_C] = sum[WIDTH];
                flags_o[FLAG_V] = (a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
            end
            OP_SHL:  result_o = shift_oob ? '0 : (a_i << shamt);
            OP_SHR:  result_o = shift_oob ? '0 : (a_i >> shamt);
            OP_MUL:  result_o = '0;
            default: err_o    = 1'b1;
        endcase
        flags_o[FLAG_N] = ~err_o & result_o[WIDTH-1];
        flags_o[FLAG_Z] = ~err_o & (result_o == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with shift-add multiply; latency 1 for single-cycle ops, WIDTH+1 for multiply.
// Backpressure: result held while out_ready is low; in_ready low during multiply or a stalled result.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             err
);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [FLAG_W-1:0]  flags_q,  flags_d;
    logic               err_q,    err_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [WIDTH-1:0]   core_result;
    logic [FLAG_W-1:0]  core_flags;
    logic               core_err;
    logic [2*WIDTH-1:0] prod_sum;
    logic               accept;

    alu_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .a_i      (a),
        .b_i      (b),
        .op_i     (op),
        .result_o (core_result),
        .flags_o  (core_flags),
        .err_o    (core_err)
    );

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign prod_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && (op == OP_MUL)) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    prod_d   = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = S_MUL;
                end else if (accept) begin
                    result_d = core_result;
                    flags_d  = core_flags;
                    err_d    = core_err;
                    state_d  = S_DONE;
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // The final iteration folds straight into the result register.
                if (cnt_q == CNT_W'(1)) begin
                    result_d        = prod_sum[WIDTH-1:0];
                    flags_d[FLAG_C] = |prod_sum[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_V] = |prod_sum[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_N] = prod_sum[WIDTH-1];
                    flags_d[FLAG_Z] = (prod_sum[WIDTH-1:0] == '0);
                    err_d           = 1'b0;
                    cnt_d           = '0;
                    state_d         = S_DONE;
                end else begin
                    prod_d   = prod_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign c      = flags_q[FLAG_C];
    assign n      = flags_q[FLAG_N];
    assign z      = flags_q[FLAG_Z];
    assign v      = flags_q[FLAG_V];
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq at WIDTH=32 against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          c, n, z, v, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outcome; f = {c, n, z, v, err}.
    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c         (c),
        .n         (n),
        .z         (z),
        .v         (v),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        logic [63:0] wide;
        longint      s;
        logic [31:0] r;
        logic        cf, vf, ef;
        r  = '0;
        cf = 1'b0;
        vf = 1'b0;
        ef = 1'b0;
        case (o)
            4'd0: r = ~x;
            4'd1: r = ~y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~(x ^ y);
            4'd6: begin
                r    = x + y;
                wide = {32'd0, x} + {32'd0, y};
                cf   = wide[32];
                s    = longint'($signed(x)) + longint'($signed(y));
                vf   = (longint'($signed(r)) != s);
            end
            4'd7: begin
                r  = x - y;
                cf = (x >= y);
                s  = longint'($signed(x)) - longint'($signed(y));
                vf = (longint'($signed(r)) != s);
            end
            4'd8: begin
                wide = {32'd0, x} * {32'd0, y};
                r    = wide[31:0];
                cf   = (wide[63:32] != 32'd0);
                vf   = cf;
            end
            4'd9:  r = (y >= 32) ? 32'd0 : (x << y[4:0]);
            4'd10: r = (y >= 32) ? 32'd0 : (x >> y[4:0]);
            default: ef = 1'b1;
        endcase
        return '{r: r, f: {cf, ~ef & r[31], ~ef & (r == 32'd0), vf, ef}};
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        int k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        op = o;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for the result, checks it, optionally stalls, then drains it.
    task automatic recv(input exp_t e, input int stall, input int exp_lat, input bit noise,
                        output bit rdy_seen);
        int lat = 1;
        rdy_seen = 1'b0;
        if (stall > 0) out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            if (noise) begin
                in_valid = 1'b1;
                op = 4'd6;
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("out_valid", 32'(out_valid), 32'd1);
        if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", result, e.r);
        chk("flags", 32'({c, n, z, v, err}), 32'(e.f));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_result", result, e.r);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit     rdy;
        exp_t   e;
        logic [31:0] x, y;
        logic [3:0]  o;
        int     stall;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'({c, n, z, v, err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Signed add overflow.
        send(32'h7FFF_FFFF, 32'd1, 4'd6);
        recv('{r: 32'h8000_0000, f: 5'b01010}, 0, 1, 1'b0, rdy);

        // Equal subtract then an AND the very next cycle, no bubble.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'd5;
        b = 32'd5;
        op = 4'd7;
        @(posedge clk);
        #1;
        a = 32'hF0F0_F0F0;
        b = 32'hFF00_FF00;
        op = 4'd2;
        @(negedge clk);
        chk("b2b_sub_valid", 32'(out_valid), 32'd1);
        chk("b2b_sub_result", result, 32'd0);
        chk("b2b_sub_flags", 32'({c, n, z, v, err}), 32'b10100);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_and_valid", 32'(out_valid), 32'd1);
        chk("b2b_and_result", result, 32'hF000_F000);
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Multiply with high-half overflow; in_valid noise must be ignored.
        send(32'h0001_0000, 32'h0001_0000, 4'd8);
        recv('{r: 32'd0, f: 5'b10110}, 0, 33, 1'b1, rdy);
        chk("mul_in_ready_low", 32'(rdy), 32'd0);
        send(32'd7, 32'd6, 4'd8);
        recv('{r: 32'd42, f: 5'b00000}, 0, 33, 1'b0, rdy);

        // Left shift under ten cycles of backpressure.
        send(32'd1, 32'd31, 4'd9);
        recv('{r: 32'h8000_0000, f: 5'b01000}, 10, 1, 1'b0, rdy);

        // Reset partway through a multiply.
        send(32'd3, 32'd5, 4'd8);
        repeat (11) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result", result, 32'd0);
        chk("midrst_flags", 32'({c, n, z, v, err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(32'd0, 32'd0, 4'd0);
        recv('{r: 32'hFFFF_FFFF, f: 5'b01000}, 0, 1, 1'b0, rdy);

        // Illegal opcode, then an oversize right shift.
        send(32'h1234_5678, 32'h9ABC_DEF0, 4'd13);
        recv('{r: 32'd0, f: 5'b00001}, 0, 1, 1'b0, rdy);
        send(32'h8000_0000, 32'd40, 4'd10);
        recv('{r: 32'd0, f: 5'b00100}, 0, 1, 1'b0, rdy);

        for (int i = 0; i < 250; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            if (o == 4'd9 || o == 4'd10) y = $urandom_range(0, 40);
            if ($urandom_range(0, 4) == 0) y = x;
            if ($urandom_range(0, 6) == 0) x = $urandom_range(0, 15);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            e = ref_op(x, y, o);
            send(x, y, o);
            recv(e, stall, (o == 4'd8) ? 33 : 1, 1'b0, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
